spi_byte_engine: RTL
====================

# spi_byte_engine

Byte-level SPI mode-0 master shifter that sits directly downstream of the SPI flash controller and drives the physical flash pins. The controller pushes command, address and dummy bytes through a valid/ready handshake, and each byte is shifted MSB-first. The received byte is returned on a one-cycle strobe. Chip select stays asserted across consecutive bytes until the controller flags the last byte of a transaction.

## Interface
- CLK_DIV, 2, SCK half-period in clk cycles (D); legal range ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_valid  in  1  byte offered by controller.
- tx_ready  out  1  engine can accept a byte (combinational from state).
- tx_data  in  8  byte to transmit, MSB first.
- tx_last  in  1  sampled with tx_data; deassert CS after this byte.
- rx_valid  out  1  one-cycle strobe: rx_data holds the byte just received.
- rx_data  out  8  received byte.
- busy  out  1  high whenever state ≠ IDLE.
- spi_sck  out  1  SPI clock, idles low (CPOL=0).
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  serial data to flash.
- spi_miso  in  1  serial data from flash.

## Operation
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, rx_valid=0, rx_data=0, busy=0, state=IDLE (so tx_ready=1). All outputs take these values immediately on rst, including mid-byte; a partial byte is discarded with no rx_valid.
- States:
  - IDLE: cs_n high, tx_ready=1.
  - SHIFT: tx_ready=0.
  - HOLD: cs_n low, sck low, tx_ready=1.
  - CS_HOLD: cs_n low, sck low, D cycles.
  - CS_GAP: cs_n high, D cycles.
- Transfer: tx_valid&&tx_ready on a clk edge.
  - Latch tx_data into the shift register and tx_last into a flag.
  - Drive spi_mosi=tx_data[7] on the same edge.
  - Go to SHIFT. From IDLE, cs_n also falls on this edge.
- SHIFT: each bit is D cycles of sck low followed by D cycles of sck high.
  - The first low phase of a byte also serves as CS setup.
  - spi_miso is sampled on the edge that ends each high phase (sck falling).
  - On that same edge, mosi advances to the next bit.
  - Half-period counter width is clog2(CLK_DIV)+1; bit counter is 3 bits.
- After bit 0's high phase:
  - sck returns low.
  - rx_data is updated with all 8 sampled bits (first sample in bit 7) and rx_valid pulses for exactly 1 cycle.
  - Next state is CS_HOLD if the tx_last flag is set, otherwise HOLD.
- HOLD:
  - Waits indefinitely with CS low; the controller owns timeout policy.
  - On accept, goes straight to SHIFT with no extra setup.
- CS_HOLD→CS_GAP: cs_n rises on entry to CS_GAP. CS_GAP→IDLE.
- tx_valid while tx_ready=0 is ignored. The controller holds valid/data stable until accepted.
- tx_last on a byte accepted in HOLD ends the transaction after that byte.
- spi_mosi holds its last value when not shifting.

## Timing
- Take the accept edge as E.
  - sck rises at E+D, E+3D, … and falls at E+2D, … E+16D.
  - rx_valid is high in the cycle following edge E+16D.
- Not last: tx_ready=1 from E+16D. A same-cycle accept (edge E+16D+1) restarts the sequence from that edge.
  - Minimum byte period is 16D+1 cycles.
- Last: cs_n rises at E+17D and the engine is in IDLE (tx_ready=1) from E+18D.
  - Minimum CS-high gap is D cycles.
- rx_valid never coincides with tx_ready=0→1 in IDLE for a last byte; rx_valid precedes return to IDLE by 2D cycles.
- MISO setup requirement: valid at the clk edge ending the high phase, i.e. at least D clk cycles after sck rises.

## Test plan
- Reset idle check, D=2: hold rst → cs_n=1, sck=0, mosi=0, rx_valid=0, tx_ready=1, busy=0.
- Single byte, D=2, tx_data=0x9F, tx_last=1, with a MISO model returning 0xA5:
  - mosi bits 1,0,0,1,1,1,1,1.
  - 8 sck pulses of 2 high / 2 low.
  - rx_valid one cycle with rx_data=0xA5 at E+32.
  - cs_n high at E+34; tx_ready at E+36.
- Multi-byte, D=1: bytes 0x03,0x00,0x10,0x00,0xFF with last on the fifth, valid held continuously.
  - cs_n stays low throughout; 40 sck pulses.
  - 5 rx_valid strobes spaced 17 cycles apart.
  - cs_n rises once.
- HOLD stall: send 0x05 with tx_last=0, then keep tx_valid low for 50 cycles.
  - cs_n stays low, sck low, tx_ready=1, busy=1.
  - Then send 0x00 with last → normal completion.
- Reset mid-byte: assert rst at E+7 (D=2).
  - Same-instant cs_n=1 and sck=0; no rx_valid.
  - After release, a new 0x9F transfer is correct.
- Backpressure: toggle tx_data while tx_ready=0 → transmitted byte equals the value present at the accept edge only.

Source files
------------

// File: rtl/spi_byte_engine_if.sv
// -----------------------------------------------------------------------------
// spi_byte_engine_if
//
// Purpose
//    Bundles the byte handshake between the flash controller and the SPI byte
//    engine together with the four physical flash pins, so the engine exposes a
//    single bus port next to its clk/rst.
//
// Signals
//    tx_valid  controller -> engine   byte offered
//    tx_ready  engine -> controller   engine can take a byte this cycle
//    tx_data   controller -> engine   byte to send, MSB first
//    tx_last   controller -> engine   release chip select after this byte
//    rx_valid  engine -> controller   one-cycle strobe, rx_data is fresh
//    rx_data   engine -> controller   byte received from the flash
//    busy      engine -> controller   engine is not idle
//    spi_sck   engine -> flash        SPI clock, idles low
//    spi_cs_n  engine -> flash        chip select, active low
//    spi_mosi  engine -> flash        serial data out
//    spi_miso  flash -> engine        serial data in
//
// Modports
//    master : controller / flash side (drives the byte request and MISO)
//    slave  : the byte engine itself
// -----------------------------------------------------------------------------
interface spi_byte_engine_if;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy;
   logic       spi_sck;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;

   modport master (
      output tx_valid, tx_data, tx_last, spi_miso,
      input  tx_ready, rx_valid, rx_data, busy, spi_sck, spi_cs_n, spi_mosi
   );

   modport slave (
      input  tx_valid, tx_data, tx_last, spi_miso,
      output tx_ready, rx_valid, rx_data, busy, spi_sck, spi_cs_n, spi_mosi
   );
endinterface

// File: rtl/spi_byte_engine.sv
// -----------------------------------------------------------------------------
// spi_byte_engine
//
// Purpose
//    Byte-level SPI mode-0 (CPOL=0, CPHA=0) master shifter that drives the flash
//    pins on behalf of the flash controller. Each accepted byte is shifted out
//    MSB first while the flash's reply is shifted in; the received byte is
//    returned on a one-cycle strobe. Chip select stays low across consecutive
//    bytes until a byte flagged tx_last has completed, after which CS is held
//    low for one half-period, then kept high for at least one half-period.
//
// Parameters
//    CLK_DIV  SCK half-period in clk cycles (D), must be >= 1.
//
// Ports
//    clk   system clock, all logic on its rising edge
//    rst   asynchronous, active-high reset; outputs go to idle values at once
//    bus   spi_byte_engine_if.slave: handshake, receive strobe, busy, SPI pins
//
// Byte timing with accept edge E
//    sck rises at E+D, E+3D, ... and falls at E+2D, ..., E+16D.
//    MISO is sampled (and MOSI advanced) on each edge that drops sck.
//    rx_valid is high in the cycle after E+16D.
//    Not last : engine is ready again from E+16D (HOLD, CS low).
//    Last     : CS rises at E+17D, engine is IDLE from E+18D.
// -----------------------------------------------------------------------------
module spi_byte_engine #(
   parameter int CLK_DIV = 2
) (
   input logic              clk,
   input logic              rst,
   spi_byte_engine_if.slave bus
);

   // Half-period counter is one bit wider than clog2 so CLK_DIV=1 still gets a
   // legal (1-bit) vector.
   localparam int            CW        = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SHIFT   = 3'd1,
      S_HOLD    = 3'd2,
      S_CS_HOLD = 3'd3,
      S_CS_GAP  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;          // cycles spent in the current half-period
   logic [2:0]    bit_q, bit_d;          // bits completed in the current byte
   logic [6:0]    tx_sr_q, tx_sr_d;      // remaining bits after the one on MOSI
   logic [6:0]    rx_sr_q, rx_sr_d;      // first seven samples of the byte
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          last_q, last_d;        // tx_last captured with the byte
   logic          sck_q, sck_d;
   logic          cs_n_q, cs_n_d;
   logic          mosi_q, mosi_d;

   logic          tx_ready;
   logic          accept;
   logic          half_done;
   logic          byte_done;

   // Ready is purely a function of state so the controller sees it without
   // any dependence on its own valid.
   assign tx_ready  = (state_q == S_IDLE) || (state_q == S_HOLD);
   assign accept    = bus.tx_valid && tx_ready;
   assign half_done = (cnt_q == HALF_LAST);
   // End of the high phase of bit 0: the falling sck edge that completes a byte.
   assign byte_done = (state_q == S_SHIFT) && half_done && sck_q && (bit_q == 3'd7);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_HOLD: begin
            // From HOLD there is no extra setup: the first low phase of the
            // new byte already gives the flash its MOSI setup time.
            if (accept) begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (byte_done) begin
               state_d = last_q ? S_CS_HOLD : S_HOLD;
            end
         end
         S_CS_HOLD: begin
            if (half_done) begin
               state_d = S_CS_GAP;
            end
         end
         S_CS_GAP: begin
            if (half_done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output / datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;          // strobe: high for exactly one cycle
      last_d     = last_q;
      sck_d      = sck_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;        // MOSI holds its last value when not shifting

      case (state_q)
         S_IDLE, S_HOLD: begin
            if (accept) begin
               // The MSB goes straight onto MOSI on the accept edge; only the
               // lower seven bits need to be kept for later.
               tx_sr_d = bus.tx_data[6:0];
               last_d  = bus.tx_last;
               mosi_d  = bus.tx_data[7];
               cs_n_d  = 1'b0;
               sck_d   = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end

         S_SHIFT: begin
            if (half_done) begin
               cnt_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  // Falling sck edge: sample MISO, then move MOSI on.
                  sck_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     rx_data_d  = {rx_sr_q, bus.spi_miso};
                     rx_valid_d = 1'b1;
                  end else begin
                     rx_sr_d = {rx_sr_q[5:0], bus.spi_miso};
                     mosi_d  = tx_sr_q[6];
                     tx_sr_d = {tx_sr_q[5:0], 1'b0};
                     bit_d   = bit_q + 3'd1;
                  end
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_CS_HOLD: begin
            // CS stays low for one half-period after the last falling sck,
            // then rises as the gap phase begins.
            if (half_done) begin
               cnt_d  = '0;
               cs_n_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_CS_GAP: begin
            if (half_done) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath / output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         bit_q      <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         last_q     <= 1'b0;
         sck_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         last_q     <= last_d;
         sck_q      <= sck_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: every pin comes straight from a flop, so reset reaches them
   // immediately and nothing glitches on the flash side.
   // -------------------------------------------------------------------------
   assign bus.tx_ready = tx_ready;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.spi_sck  = sck_q;
   assign bus.spi_cs_n = cs_n_q;
   assign bus.spi_mosi = mosi_q;

endmodule
